// File: rtl/machine_ctl.sv
// Eight-state instruction-cycle sequencer for the RISC core.
// Every strobe is registered so it lines up exactly with the state it belongs to.
module machine_ctl #(
    parameter int OP_W = 3
) (
    input  logic            clock,
    input  logic            rst,
    input  logic            ena,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            pc_step,
    output logic            pc_load,
    output logic            ir_load,
    output logic            acc_load,
    output logic            rd,
    output logic            wr,
    output logic            data_ena,
    output logic            halt,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
        S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
    } state_t;

    localparam logic [OP_W-1:0] OP_HLT = 3'b000;
    localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_LDA = 3'b101;
    localparam logic [OP_W-1:0] OP_STO = 3'b110;
    localparam logic [OP_W-1:0] OP_JMP = 3'b111;

    state_t          state_q, state_d;
    logic            run_q, run_d;
    logic            halted_q, halted_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            zero_q, zero_d;
    logic            adv, mem, skip;
    logic            ps_d, pl_d, ir_d, acc_d, rd_d, wr_d, de_d;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= S0;
            run_q    <= 1'b0;
            halted_q <= 1'b0;
            op_q     <= '0;
            zero_q   <= 1'b0;
            pc_step  <= 1'b0;
            pc_load  <= 1'b0;
            ir_load  <= 1'b0;
            acc_load <= 1'b0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            data_ena <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            halted_q <= halted_d;
            op_q     <= op_d;
            zero_q   <= zero_d;
            pc_step  <= ps_d;
            pc_load  <= pl_d;
            ir_load  <= ir_d;
            acc_load <= acc_d;
            rd       <= rd_d;
            wr       <= wr_d;
            data_ena <= de_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        halted_d = halted_q;
        op_d     = op_q;
        zero_d   = zero_q;
        ps_d     = 1'b0;
        pl_d     = 1'b0;
        ir_d     = 1'b0;
        acc_d    = 1'b0;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        de_d     = 1'b0;
        adv      = run_q & ena & ~halted_q;

        // An idle S0 (after reset or ena low) spends one cycle arming before fetch.
        if (!halted_q) begin
            if (!ena) begin
                state_d = S0;
                run_d   = 1'b0;
            end else if (!run_q) begin
                state_d = S0;
                run_d   = 1'b1;
            end else begin
                state_d = state_t'(state_q + 3'd1);
            end
        end

        if (adv && state_q == S2) op_d = opcode;
        if (adv && state_q == S3) begin
            zero_d = zero;
            if (op_q == OP_HLT) halted_d = 1'b1;
        end

        mem  = (op_d == OP_ADD) || (op_d == OP_AND) ||
               (op_d == OP_XOR) || (op_d == OP_LDA);
        skip = (op_d == OP_SKZ) && zero_d;

        // Strobes are decoded from the state being entered, then registered.
        if (run_d && !halted_d) begin
            case (state_d)
                S0, S1: begin
                    rd_d = 1'b1;
                    ir_d = 1'b1;
                    ps_d = 1'b1;
                end
                S4: begin
                    ps_d = skip || (op_d == OP_JMP);
                    pl_d = (op_d == OP_JMP);
                    rd_d = mem;
                    de_d = (op_d == OP_STO);
                end
                S5: begin
                    rd_d  = mem;
                    acc_d = mem;
                    wr_d  = (op_d == OP_STO);
                    de_d  = (op_d == OP_STO);
                end
                S6: begin
                    ps_d = skip;
                    de_d = (op_d == OP_STO);
                end
                default: ;
            endcase
        end
    end

    assign halt  = halted_q;
    assign state = state_q;

endmodule

// File: tb/tb_machine_ctl.sv
// Bench for machine_ctl: cycle model of the instruction sequence plus
// directed instructions checked against hand-computed per-state strobe masks.
module tb_machine_ctl;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       ena   = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero  = 1'b0;
    logic       pc_step, pc_load, ir_load, acc_load;
    logic       rd, wr, data_ena, halt;
    logic [2:0] state;

    machine_ctl dut (
        .clock(clock), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
        .pc_step(pc_step), .pc_load(pc_load), .ir_load(ir_load),
        .acc_load(acc_load), .rd(rd), .wr(wr), .data_ena(data_ena),
        .halt(halt), .state(state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe vector order: pc_step pc_load ir_load acc_load rd wr data_ena
    function automatic logic [6:0] exp_out(int s, int op, bit z);
        bit memop;
        logic [6:0] v;
        memop = (op >= 2 && op <= 5);
        v = 7'b0;
        case (s)
            0, 1: v = 7'b1010100;
            4: begin
                if (op == 1 && z) v[6] = 1'b1;
                if (op == 7) v[6:5] = 2'b11;
                if (memop) v[2] = 1'b1;
                if (op == 6) v[0] = 1'b1;
            end
            5: begin
                if (memop) begin v[3] = 1'b1; v[2] = 1'b1; end
                if (op == 6) begin v[1] = 1'b1; v[0] = 1'b1; end
            end
            6: begin
                if (op == 1 && z) v[6] = 1'b1;
                if (op == 6) v[0] = 1'b1;
            end
            default: v = 7'b0;
        endcase
        return v;
    endfunction

    int         m_state = 0;
    int         m_run = 0;
    int         m_halt = 0;
    int         m_op = 0;
    bit         m_zero = 1'b0;
    logic [6:0] m_out = 7'b0;
    bit         m_valid = 1'b0;

    always @(posedge clock) begin
        if (rst) begin
            m_state = 0; m_run = 0; m_halt = 0; m_op = 0;
            m_zero = 1'b0; m_out = 7'b0; m_valid = 1'b1;
        end else if (m_halt != 0) begin
            m_out = 7'b0;
        end else if (!ena) begin
            m_state = 0; m_run = 0; m_out = 7'b0;
        end else begin
            if (m_run == 0) begin
                m_run = 1;
                m_state = 0;
            end else begin
                if (m_state == 2) m_op = int'(opcode);
                if (m_state == 3) begin
                    m_zero = zero;
                    if (m_op == 0) m_halt = 1;
                end
                m_state = (m_state + 1) % 8;
            end
            m_out = (m_halt != 0) ? 7'b0 : exp_out(m_state, m_op, m_zero);
        end
    end

    logic [6:0] dut_vec;
    assign dut_vec = {pc_step, pc_load, ir_load, acc_load, rd, wr, data_ena};

    always @(negedge clock) begin
        if (m_valid) begin
            chk("model_state", int'(state), m_state);
            chk("model_strobes", int'(dut_vec), int'(m_out));
            chk("model_halt", int'(halt), m_halt);
            chk("rd_wr_exclusive", int'(rd & wr), 0);
        end
    end

    logic [7:0] mk_ps, mk_pl, mk_ir, mk_acc, mk_rd, mk_wr, mk_de;

    task automatic clr();
        mk_ps = 0; mk_pl = 0; mk_ir = 0; mk_acc = 0;
        mk_rd = 0; mk_wr = 0; mk_de = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (pc_step)  mk_ps[state]  = 1'b1;
        if (pc_load)  mk_pl[state]  = 1'b1;
        if (ir_load)  mk_ir[state]  = 1'b1;
        if (acc_load) mk_acc[state] = 1'b1;
        if (rd)       mk_rd[state]  = 1'b1;
        if (wr)       mk_wr[state]  = 1'b1;
        if (data_ena) mk_de[state]  = 1'b1;
    endtask

    task automatic run_ticks(input int n, input bit z3, input bit za);
        zero = za;
        repeat (n) begin
            tick();
            zero = (m_state == 3) ? z3 : za;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b0;
        tick();
        rst = 1'b0;
        clr();
    endtask

    task automatic start(input logic [2:0] op);
        do_reset();
        opcode = op;
        ena = 1'b1;
        clr();
    endtask

    initial begin
        do_reset();
        chk("reset_state", int'(state), 0);
        chk("reset_strobes", int'(dut_vec), 0);
        chk("reset_halt", int'(halt), 0);

        // ADD: full cycle then wrap into next fetch
        start(3'b010);
        run_ticks(8, 1'b0, 1'b0);
        chk("add_pc_step", int'(mk_ps), 8'h03);
        chk("add_rd", int'(mk_rd), 8'h33);
        chk("add_acc_load", int'(mk_acc), 8'h20);
        chk("add_ir_load", int'(mk_ir), 8'h03);
        chk("add_wr", int'(mk_wr), 8'h00);
        tick();
        chk("add_wrap_state", int'(state), 0);
        chk("add_wrap_fetch", int'(pc_step), 1);

        // SKZ with zero latched high, then dropped
        start(3'b001);
        run_ticks(8, 1'b1, 1'b0);
        chk("skz1_pc_step", int'(mk_ps), 8'h53);
        chk("skz1_pc_load", int'(mk_pl), 8'h00);
        start(3'b001);
        run_ticks(8, 1'b0, 1'b0);
        chk("skz0_pc_step", int'(mk_ps), 8'h03);

        // JMP
        start(3'b111);
        run_ticks(8, 1'b0, 1'b0);
        chk("jmp_pc_step", int'(mk_ps), 8'h13);
        chk("jmp_pc_load", int'(mk_pl), 8'h10);
        chk("jmp_rd", int'(mk_rd), 8'h03);
        chk("jmp_wr", int'(mk_wr), 8'h00);

        // STO
        start(3'b110);
        run_ticks(8, 1'b0, 1'b0);
        chk("sto_rd", int'(mk_rd), 8'h03);
        chk("sto_wr", int'(mk_wr), 8'h20);
        chk("sto_data_ena", int'(mk_de), 8'h70);
        chk("sto_acc_load", int'(mk_acc), 8'h00);

        // LDA with opcode changing after it was latched
        start(3'b101);
        run_ticks(4, 1'b0, 1'b0);
        opcode = 3'b111;
        run_ticks(4, 1'b0, 1'b0);
        chk("lda_rd", int'(mk_rd), 8'h33);
        chk("lda_acc_load", int'(mk_acc), 8'h20);
        chk("lda_pc_load", int'(mk_pl), 8'h00);

        // Reset in S5 of STO
        start(3'b110);
        run_ticks(6, 1'b0, 1'b0);
        chk("sto_s5_state", int'(state), 5);
        chk("sto_s5_wr", int'(wr), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", int'(state), 0);
        chk("abort_wr", int'(wr), 0);
        chk("abort_data_ena", int'(data_ena), 0);
        chk("abort_halt", int'(halt), 0);

        // HLT freezes in S4 until reset
        start(3'b000);
        run_ticks(4, 1'b0, 1'b0);
        tick();
        chk("hlt_state", int'(state), 4);
        chk("hlt_halt", int'(halt), 1);
        clr();
        repeat (20) begin
            tick();
            chk("hlt_frozen", int'(state), 4);
        end
        chk("hlt_no_strobes", int'(mk_ps | mk_rd | mk_wr | mk_de | mk_ir | mk_acc | mk_pl), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hlt_rst_state", int'(state), 0);
        chk("hlt_rst_halt", int'(halt), 0);

        // ena dropped in S3
        start(3'b010);
        run_ticks(4, 1'b0, 1'b0);
        chk("ena_s3", int'(state), 3);
        ena = 1'b0;
        tick();
        chk("ena_off_state", int'(state), 0);
        chk("ena_off_strobes", int'(dut_vec), 0);
        repeat (3) tick();
        chk("ena_idle_strobes", int'(dut_vec), 0);
        ena = 1'b1;
        tick();
        chk("ena_on_state", int'(state), 0);
        chk("ena_on_fetch", int'(dut_vec), 7'b1010100);
        tick();
        chk("ena_on_s1", int'(state), 1);

        ena = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
